// File: rtl/ntt_result_collector_pkg.sv
// Shared definitions for the NTT result collector.
// Holds the buffer depth, the power-on modulus / ring size, the collector
// state encoding and the butterfly PE depth of the upstream NTT core.
package ntt_result_collector_pkg;

  localparam int          MAX_N_DEF  = 1024;     // largest ring size (buffer depth)
  localparam int          DEFAULT_N  = 256;      // ring size latched at reset
  localparam logic [15:0] DEFAULT_Q  = 16'd3329; // Kyber modulus, latched at reset
  localparam int          PE_DEPTH   = 2;        // butterfly PE pipeline depth of the core

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_READY   = 2'd2
  } state_e;

endpackage

// File: rtl/ntt_result_collector_if.sv
// Bundle of all collector signals except clk/reset.
// master: NTT core + reader side (drives core stream, control, read request).
// slave : the collector (drives read data, status and debug state).
//
// Handshakes: the core stream has no back-pressure; a word is transferred on
// every rising edge where dout_valid=1 and is accepted only in CAPTURE.
// A read is requested by rd_en=1 at edge t and answered with rd_valid=1 and
// rd_data during cycle t+1; rd_valid is a single-cycle qualifier.
interface ntt_result_collector_if #(
  parameter int COEF_W = 32,
  parameter int ADDR_W = 10
);
  import ntt_result_collector_pkg::*;

  logic              core_done;
  logic              dout_valid;
  logic [COEF_W-1:0] dout0;
  logic [15:0]       q;
  logic [11:0]       ring_size;
  logic              clear;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [COEF_W-1:0] rd_data;
  logic              rd_valid;
  logic              full;
  logic              overflow;
  logic [ADDR_W:0]   count;
  state_e            state;

  modport master (
    output core_done, dout_valid, dout0, q, ring_size, clear, rd_en, rd_addr,
    input  rd_data, rd_valid, full, overflow, count, state
  );

  modport slave (
    input  core_done, dout_valid, dout0, q, ring_size, clear, rd_en, rd_addr,
    output rd_data, rd_valid, full, overflow, count, state
  );

endinterface

// File: rtl/ntt_coef_ram.sv
// Coefficient buffer: simple dual-port RAM, one write port and one
// registered read port. No reset on the array or read register so it maps
// onto block RAM; contents survive clear and reset.
// Ports: clk, we/waddr/wdata (write), re/raddr (read request), rdata (registered).
module ntt_coef_ram #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ntt_result_collector.sv
// NTT result collector: captures the core's even/odd-interleaved, lazily
// reduced output stream into natural order, fully reduced, and serves
// random-access reads once all N coefficients are in.
// Ports: clk, reset (async, active-high), bus (ntt_result_collector_if.slave)
//   carrying core stream, control, read port, status and debug state.
module ntt_result_collector
  import ntt_result_collector_pkg::*;
#(
  parameter int COEF_W = 32,
  parameter int MAX_N  = MAX_N_DEF,
  parameter int ADDR_W = 10
) (
  input logic                  clk,
  input logic                  reset,
  ntt_result_collector_if.slave bus
);

  state_e            state;
  logic [ADDR_W:0]   count;
  logic [11:0]       n_lat;
  logic [15:0]       q_lat;
  logic              full_r;
  logic              overflow_r;
  logic              rd_valid_r;
  logic              rd_zero;   // last accepted read was out of range (or none since reset)

  logic [COEF_W-1:0] q_ext;
  logic [COEF_W-1:0] red_word;
  logic [COEF_W-1:0] ram_rdata;
  logic [11:0]       m_ext;
  logic [11:0]       half_n;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_en;
  logic              rd_fire;
  logic              last_word;
  logic              rd_oob;

  // Single conditional subtract: input is in [0, 2q).
  assign q_ext    = COEF_W'(q_lat);
  assign red_word = (bus.dout0 >= q_ext) ? (bus.dout0 - q_ext) : bus.dout0;

  // Core emits pairs (even, odd); even words fill the low half, odd the high half.
  assign m_ext   = 12'(count);
  assign half_n  = n_lat >> 1;
  assign wr_addr = count[0] ? ADDR_W'((m_ext >> 1) + half_n) : ADDR_W'(m_ext >> 1);

  assign last_word = (m_ext == (n_lat - 12'd1));
  assign rd_oob    = (12'(bus.rd_addr) >= n_lat);

  assign wr_en   = (state == ST_CAPTURE) && bus.dout_valid && !bus.clear;
  assign rd_fire = (state == ST_READY)   && bus.rd_en      && !bus.clear;

  ntt_coef_ram #(
    .WIDTH  (COEF_W),
    .DEPTH  (MAX_N),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (red_word),
    .re    (rd_fire),
    .raddr (bus.rd_addr),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      count      <= '0;
      full_r     <= 1'b0;
      overflow_r <= 1'b0;
      rd_valid_r <= 1'b0;
      rd_zero    <= 1'b1;
      n_lat      <= 12'(DEFAULT_N);
      q_lat      <= DEFAULT_Q;
    end else begin
      rd_valid_r <= 1'b0;
      if (bus.clear) begin
        state      <= ST_IDLE;
        count      <= '0;
        full_r     <= 1'b0;
        overflow_r <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (bus.core_done) begin
              state <= ST_CAPTURE;
              n_lat <= bus.ring_size;
              q_lat <= bus.q;
              count <= '0;
            end else if (bus.dout_valid) begin
              overflow_r <= 1'b1;
            end
          end
          ST_CAPTURE: begin
            if (bus.dout_valid) begin
              count <= count + (ADDR_W+1)'(1);
              if (last_word) begin
                state  <= ST_READY;
                full_r <= 1'b1;
              end
            end
          end
          ST_READY: begin
            if (bus.dout_valid) overflow_r <= 1'b1;
            if (bus.rd_en) begin
              rd_valid_r <= 1'b1;
              rd_zero    <= rd_oob;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // RAM read register has no reset; rd_zero masks it to 0 after reset and
  // for out-of-range reads, and both hold when no read is accepted.
  assign bus.rd_data  = rd_zero ? '0 : ram_rdata;
  assign bus.rd_valid = rd_valid_r;
  assign bus.full     = full_r;
  assign bus.overflow = overflow_r;
  assign bus.count    = count;
  assign bus.state    = state;

endmodule

// File: tb/tb_ntt_result_collector.sv
module tb_ntt_result_collector;
  import ntt_result_collector_pkg::*;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  logic [31:0] exp_q[$];

  ntt_result_collector_if bus_if ();

  ntt_result_collector dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_capture(input logic [11:0] n, input logic [15:0] qv);
    bus_if.core_done = 1'b1;
    bus_if.ring_size = n;
    bus_if.q         = qv;
    tick();
    bus_if.core_done = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    bus_if.dout_valid = 1'b1;
    bus_if.dout0      = w;
    tick();
  endtask

  task automatic read_at(input int addr);
    bus_if.rd_en   = 1'b1;
    bus_if.rd_addr = 10'(addr);
    tick();
    bus_if.rd_en   = 1'b0;
  endtask

  task automatic read_cmp(input string tag, input int addr, input logic [31:0] exp);
    read_at(addr);
    check({tag, "_valid"}, 64'(bus_if.rd_valid), 64'd1);
    check({tag, "_data"}, 64'(bus_if.rd_data), 64'(exp));
  endtask

  // natural-order index k of an N=256 capture holds stream word m
  function automatic int deint256(input int k);
    return (k < 128) ? 2 * k : 2 * (k - 128) + 1;
  endfunction

  // scoreboard: expected queue filled first, then drained by reads
  task automatic read_all_256(input string tag, input int offset);
    logic [31:0] e;
    for (int k = 0; k < 256; k++) exp_q.push_back(32'(deint256(k) + offset));
    for (int k = 0; k < 256; k++) begin
      read_at(k);
      e = exp_q.pop_front();
      check({tag, "_valid"}, 64'(bus_if.rd_valid), 64'd1);
      check({tag, "_data"}, 64'(bus_if.rd_data), 64'(e));
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] red_in [4];
    total = 0;
    bad   = 0;
    red_in[0] = 32'd3328;
    red_in[1] = 32'd3329;
    red_in[2] = 32'd3330;
    red_in[3] = 32'd6657;

    reset             = 1'b1;
    bus_if.core_done  = 1'b0;
    bus_if.dout_valid = 1'b0;
    bus_if.dout0      = '0;
    bus_if.q          = 16'd3329;
    bus_if.ring_size  = 12'd256;
    bus_if.clear      = 1'b0;
    bus_if.rd_en      = 1'b0;
    bus_if.rd_addr    = '0;

    tick();
    check("rst_state", 64'(bus_if.state), 64'(ST_IDLE));
    check("rst_count", 64'(bus_if.count), 64'd0);
    check("rst_full", 64'(bus_if.full), 64'd0);
    check("rst_overflow", 64'(bus_if.overflow), 64'd0);
    check("rst_rd_valid", 64'(bus_if.rd_valid), 64'd0);
    check("rst_rd_data", 64'(bus_if.rd_data), 64'd0);
    reset = 1'b0;
    tick();

    // read outside READY is ignored
    read_at(3);
    check("idle_rd_valid", 64'(bus_if.rd_valid), 64'd0);
    check("idle_rd_data", 64'(bus_if.rd_data), 64'd0);

    // basic capture, dout0 = m
    start_capture(12'd256, 16'd3329);
    check("cap_state", 64'(bus_if.state), 64'(ST_CAPTURE));
    check("cap_count0", 64'(bus_if.count), 64'd0);
    for (int m = 0; m < 255; m++) send_word(32'(m));
    check("cap_full_early", 64'(bus_if.full), 64'd0);
    check("cap_count255", 64'(bus_if.count), 64'd255);
    send_word(32'd255);
    bus_if.dout_valid = 1'b0;
    check("cap_full", 64'(bus_if.full), 64'd1);
    check("cap_count256", 64'(bus_if.count), 64'd256);
    check("cap_ready", 64'(bus_if.state), 64'(ST_READY));
    read_all_256("basic", 0);

    // out-of-range, then in-range, then hold
    read_cmp("rd_oob", 300, 32'd0);
    read_cmp("rd_5", 5, 32'd10);
    tick();
    check("rd_hold_valid", 64'(bus_if.rd_valid), 64'd0);
    check("rd_hold_data", 64'(bus_if.rd_data), 64'd10);

    // core_done in READY does not restart
    bus_if.core_done = 1'b1;
    tick();
    bus_if.core_done = 1'b0;
    check("done_in_ready_state", 64'(bus_if.state), 64'(ST_READY));
    check("done_in_ready_count", 64'(bus_if.count), 64'd256);

    // extra word in READY
    send_word(32'hdead);
    bus_if.dout_valid = 1'b0;
    check("ovf_ready", 64'(bus_if.overflow), 64'd1);
    check("ovf_ready_count", 64'(bus_if.count), 64'd256);
    read_cmp("ovf_buf0", 0, 32'd0);

    // clear beats simultaneous word and read
    bus_if.clear      = 1'b1;
    bus_if.dout_valid = 1'b1;
    bus_if.rd_en      = 1'b1;
    bus_if.rd_addr    = 10'd5;
    tick();
    bus_if.clear      = 1'b0;
    bus_if.dout_valid = 1'b0;
    bus_if.rd_en      = 1'b0;
    check("clr_state", 64'(bus_if.state), 64'(ST_IDLE));
    check("clr_count", 64'(bus_if.count), 64'd0);
    check("clr_full", 64'(bus_if.full), 64'd0);
    check("clr_overflow", 64'(bus_if.overflow), 64'd0);
    check("clr_rd_valid", 64'(bus_if.rd_valid), 64'd0);

    // word in IDLE without core_done
    send_word(32'd77);
    bus_if.dout_valid = 1'b0;
    check("ovf_idle", 64'(bus_if.overflow), 64'd1);
    check("ovf_idle_count", 64'(bus_if.count), 64'd0);
    bus_if.clear = 1'b1;
    tick();
    bus_if.clear = 1'b0;
    check("ovf_idle_clr", 64'(bus_if.overflow), 64'd0);

    // reduction; q input changes after latch and must not matter
    start_capture(12'd256, 16'd3329);
    bus_if.q = 16'd7;
    for (int m = 0; m < 4; m++) send_word(red_in[m]);
    for (int m = 4; m < 256; m++) send_word(32'(m));
    bus_if.dout_valid = 1'b0;
    bus_if.q = 16'd3329;
    check("red_full", 64'(bus_if.full), 64'd1);
    read_cmp("red_3328", 0, 32'd3328);
    read_cmp("red_3329", 128, 32'd0);
    read_cmp("red_3330", 1, 32'd1);
    read_cmp("red_6657", 129, 32'd3328);
    read_cmp("red_m4", 2, 32'd4);
    read_cmp("red_m5", 130, 32'd5);

    // 8 bursts of 32 with one-cycle gaps
    bus_if.clear = 1'b1;
    tick();
    bus_if.clear = 1'b0;
    start_capture(12'd256, 16'd3329);
    for (int b = 0; b < 8; b++) begin
      for (int i = 0; i < 32; i++) send_word(32'(b * 32 + i));
      bus_if.dout_valid = 1'b0;
      bus_if.dout0      = 32'hffff;
      tick();
      if (b == 3) begin
        check("burst_mid_count", 64'(bus_if.count), 64'd128);
        check("burst_mid_state", 64'(bus_if.state), 64'(ST_CAPTURE));
      end
    end
    check("burst_count", 64'(bus_if.count), 64'd256);
    check("burst_full", 64'(bus_if.full), 64'd1);
    read_all_256("burst", 0);

    // reset after 100 words discards progress
    bus_if.clear = 1'b1;
    tick();
    bus_if.clear = 1'b0;
    start_capture(12'd256, 16'd3329);
    for (int m = 0; m < 100; m++) send_word(32'(1000 + m));
    bus_if.dout_valid = 1'b0;
    check("pre_rst_count", 64'(bus_if.count), 64'd100);
    #2 reset = 1'b1;
    #1;
    check("async_rst_state", 64'(bus_if.state), 64'(ST_IDLE));
    check("async_rst_count", 64'(bus_if.count), 64'd0);
    check("async_rst_full", 64'(bus_if.full), 64'd0);
    tick();
    reset = 1'b0;
    tick();
    start_capture(12'd256, 16'd3329);
    check("re_cap_count0", 64'(bus_if.count), 64'd0);
    for (int m = 0; m < 256; m++) send_word(32'(500 + m));
    bus_if.dout_valid = 1'b0;
    check("re_cap_full", 64'(bus_if.full), 64'd1);
    check("re_cap_count", 64'(bus_if.count), 64'd256);
    read_all_256("recap", 500);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ntt_result_collector.md
NTT_RESULT_COLLECTOR -- requirements
Module: ntt_result_collector

Interface
REQ-001 Parameter: COEF_W, 32, coefficient word width.
REQ-002 Parameter: MAX_N, 1024, largest ring size (buffer depth).
REQ-003 Parameter: ADDR_W, 10, log2(MAX_N).
REQ-004 One clock; reset is asynchronous and active-high.
REQ-005 Port: clk  in  1  system clock, all logic on rising edge.
REQ-006 Port: reset  in  1  asynchronous active-high reset.
REQ-007 Port: core_done  in  1  NTT core done flag, level.
REQ-008 Port: dout_valid  in  1  core output word valid this cycle.
REQ-009 Port: dout0  in  COEF_W  core output word, lazily reduced, range [0, 2q).
REQ-010 Port: q  in  16  modulus (3329 for Kyber).
REQ-011 Port: ring_size  in  12  N, power of two, 256..MAX_N.
REQ-012 Port: clear  in  1  one-cycle pulse, return to IDLE.
REQ-013 Port: rd_en  in  1  read request.
REQ-014 Port: rd_addr  in  ADDR_W  natural-order coefficient index.
REQ-015 Port: rd_data  out  COEF_W  coefficient read, fully reduced.
REQ-016 Port: rd_valid  out  1  rd_data valid.
REQ-017 Port: full  out  1  all N coefficients captured (state READY).
REQ-018 Port: overflow  out  1  sticky, valid word arrived outside CAPTURE.
REQ-019 Port: count  out  ADDR_W+1  words captured so far.

Function
REQ-020 States: IDLE, CAPTURE, READY; encoded as 2 bits.
REQ-021 IDLE -> CAPTURE on core_done=1; N and q latched that edge; count cleared.
REQ-022 In CAPTURE, each cycle with dout_valid=1 writes word m=count, then count increments; dout_valid=0 cycles (burst gaps) change nothing.
REQ-023 Write address: m even -> m>>1; m odd -> (m>>1)+N/2 (de-interleave of core's even/odd pair stream).
REQ-024 Stored value: dout0-q if dout0>=q, else dout0; compare on full COEF_W, zero-extended q.
REQ-025 CAPTURE -> READY on the edge writing m=N-1; full=1 from next cycle.
REQ-026 Reads only in READY: rd_en=1 at edge t -> rd_data=buf[rd_addr], rd_valid=1 during cycle t+1; rd_valid=0 otherwise.
REQ-027 rd_en outside READY ignored; rd_data holds last value, rd_valid=0.
REQ-028 rd_addr>=N in READY returns 0 with rd_valid=1.
REQ-029 dout_valid=1 in IDLE (core_done=0) or READY sets overflow=1; buffer and count unchanged.
REQ-030 clear=1 from any state -> IDLE, count=0, full=0, overflow=0 next cycle; clear wins over simultaneous dout_valid or rd_en.
REQ-031 core_done=1 in READY does not restart capture; only clear re-arms.
REQ-032 Buffer contents are not erased by clear or reset; only count/state gate their use.

Reset
REQ-033 reset=1: state=IDLE, count=0, full=0, overflow=0, rd_valid=0, rd_data=0, latched N=256, latched q=3329, immediately and asynchronously.
REQ-034 Reset mid-CAPTURE discards progress; next core_done starts from m=0.

Structure
REQ-035 MAX_N, default q 3329, state encodings and PE_DEPTH belong in the shared defines file.
REQ-036 Storage is one sub-module ntt_coef_ram: simple dual-port, 1 write / 1 registered read, MAX_N x COEF_W, BRAM-inferable.
REQ-037 Reduction and address generation stay combinational in the top level, no extra pipeline stage.

Verification
REQ-038 N=256, q=3329, 256 valid words dout0=m -> buf[k]=2k, buf[128+k]=2k+1; full=1 one cycle after word 255.
REQ-039 Reduction: dout0=3328/3329/3330/6657 -> stored 3328/0/1/3328.
REQ-040 8 bursts of 32 words with 1-cycle gaps, N=256 -> count=256, full=1, contents as REQ-038.
REQ-041 Extra dout_valid in READY -> overflow=1, buf[0] unchanged; clear -> overflow=0, full=0, state IDLE.
REQ-042 reset after 100 captured words -> count=0, full=0; new done + 256 words -> correct buffer.
REQ-043 READY, rd_en with rd_addr=5 -> rd_valid=1 and rd_data=buf[5] next cycle; rd_addr=300, N=256 -> rd_data=0.
